// File: rtl/mem_port_arbiter.sv
`default_nettype none
// =============================================================================
// mem_port_arbiter : shares one BRAM port between fetch and load/store, decodes
//                    MMIO, extracts load lanes and builds store byte enables.
// Revision 1.0
// =============================================================================
module mem_port_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        instrReq,
  input  logic [31:0] instrAddr,
  output logic        instrValid,
  output logic        instrErr,
  output logic [31:0] instrData,
  input  logic        dataReq,
  input  logic [31:0] dataAddr,
  input  logic [1:0]  memOp,
  input  logic [1:0]  memSize,
  input  logic [31:0] storeData,
  output logic        dataValid,
  output logic        dataErr,
  output logic [31:0] loadData,
  output logic        bramEn,
  output logic [3:0]  bramWe,
  output logic [29:0] bramAddr,
  output logic [31:0] bramWdata,
  input  logic [31:0] bramRdata,
  input  logic [31:0] inReg,
  output logic [31:0] outReg
);
  localparam logic [1:0]  MEM_DISABLE      = 2'b00;
  localparam logic [1:0]  MEM_READ_SEXT    = 2'b01;
  localparam logic [1:0]  MEM_READ_ZEXT    = 2'b10;
  localparam logic [1:0]  MEM_WRITE        = 2'b11;
  localparam logic [1:0]  SIZE_BYTE        = 2'b00;
  localparam logic [1:0]  SIZE_HALF        = 2'b01;
  localparam logic [1:0]  SIZE_WORD        = 2'b10;
  localparam logic [31:0] CPU_BRAM_END     = 32'h007F_FF00;
  localparam logic [31:0] READ_REG_INPUT   = 32'h0200_0000;
  localparam logic [31:0] WRITE_REG_OUTPUT = 32'h0200_0100;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t      state_q, state_d;
  logic        lastInstr_q, lastInstr_d;
  logic        srcData_q, srcData_d;
  logic        mmio_q, mmio_d;
  logic [1:0]  op_q, op_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  lane_q, lane_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wrep_q, wrep_d;

  logic        instrValid_q, instrValid_d, instrErr_q, instrErr_d;
  logic [31:0] instrData_q, instrData_d;
  logic        dataValid_q, dataValid_d, dataErr_q, dataErr_d;
  logic [31:0] loadData_q, loadData_d;
  logic        bramEn_q, bramEn_d;
  logic [3:0]  bramWe_q, bramWe_d;
  logic [29:0] bramAddr_q, bramAddr_d;
  logic [31:0] bramWdata_q, bramWdata_d;
  logic [31:0] outReg_q, outReg_d;

  logic        w_dataPend, w_grantData, w_store;
  logic        w_inBram, w_isIn, w_isOut, w_dataErr, w_instrErr, w_err;
  logic [31:0] w_addr;
  logic [3:0]  w_be;
  logic [31:0] w_wrep;
  logic [31:0] w_src, w_ext;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // lastInstr_q set means fetch won the previous grant, so data wins a tie
  assign w_dataPend  = dataReq && (memOp != MEM_DISABLE);
  assign w_grantData = w_dataPend && (!instrReq || lastInstr_q);
  assign w_store     = (memOp == MEM_WRITE);
  assign w_inBram    = (dataAddr <= CPU_BRAM_END);
  assign w_isIn      = (dataAddr == READ_REG_INPUT);
  assign w_isOut     = (dataAddr == WRITE_REG_OUTPUT);
  assign w_dataErr   = (memSize == 2'b11)
                     || ((memSize == SIZE_HALF) && dataAddr[0])
                     || ((memSize == SIZE_WORD) && (dataAddr[1:0] != 2'b00))
                     || !(w_inBram || w_isIn || w_isOut)
                     || (!w_store && w_isOut)
                     || (w_store && w_isIn);
  assign w_instrErr  = (instrAddr[1:0] != 2'b00) || (instrAddr > CPU_BRAM_END);
  assign w_err       = w_grantData ? w_dataErr : w_instrErr;
  assign w_addr      = w_grantData ? dataAddr : instrAddr;

  always_comb begin
    w_be   = 4'b0000;
    w_wrep = 32'h0;
    case (memSize)
      SIZE_BYTE: begin
        w_be   = 4'b0001 << dataAddr[1:0];
        w_wrep = {4{storeData[7:0]}};
      end
      SIZE_HALF: begin
        w_be   = dataAddr[1] ? 4'b1100 : 4'b0011;
        w_wrep = {2{storeData[15:0]}};
      end
      SIZE_WORD: begin
        w_be   = 4'b1111;
        w_wrep = storeData;
      end
      default: ;
    endcase
  end

  assign w_src  = mmio_q ? inReg : bramRdata;
  assign w_byte = w_src[{lane_q, 3'b000} +: 8];
  assign w_half = lane_q[1] ? w_src[31:16] : w_src[15:0];

  always_comb begin
    w_ext = 32'h0;
    case (size_q)
      SIZE_BYTE: w_ext = (op_q == MEM_READ_SEXT) ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
      SIZE_HALF: w_ext = (op_q == MEM_READ_SEXT) ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
      SIZE_WORD: w_ext = w_src;
      default:   w_ext = 32'h0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    lastInstr_d  = lastInstr_q;
    srcData_d    = srcData_q;
    mmio_d       = mmio_q;
    op_d         = op_q;
    size_d       = size_q;
    lane_d       = lane_q;
    be_d         = be_q;
    wrep_d       = wrep_q;
    instrValid_d = instrValid_q;
    instrErr_d   = instrErr_q;
    instrData_d  = instrData_q;
    dataValid_d  = dataValid_q;
    dataErr_d    = dataErr_q;
    loadData_d   = loadData_q;
    bramEn_d     = bramEn_q;
    bramWe_d     = bramWe_q;
    bramAddr_d   = bramAddr_q;
    bramWdata_d  = bramWdata_q;
    outReg_d     = outReg_q;

    case (state_q)
      IDLE: begin
        if (w_dataPend || instrReq) begin
          lastInstr_d = !w_grantData;
          srcData_d   = w_grantData;
          if (w_err) begin
            state_d = DONE;
            if (w_grantData) begin
              dataValid_d = 1'b1;
              dataErr_d   = 1'b1;
              loadData_d  = 32'h0;
            end else begin
              instrValid_d = 1'b1;
              instrErr_d   = 1'b1;
              instrData_d  = 32'h0;
            end
          end else begin
            state_d = ACCESS;
            op_d    = w_grantData ? memOp : MEM_READ_ZEXT;
            size_d  = w_grantData ? memSize : SIZE_WORD;
            lane_d  = w_addr[1:0];
            mmio_d  = w_grantData && !w_inBram;
            be_d    = w_be;
            wrep_d  = w_wrep;
            if (!(w_grantData && !w_inBram)) begin
              bramEn_d    = 1'b1;
              bramAddr_d  = w_addr[31:2];
              bramWe_d    = (w_grantData && w_store) ? w_be : 4'b0000;
              bramWdata_d = (w_grantData && w_store) ? w_wrep : 32'h0;
            end
          end
        end
      end
      ACCESS: begin
        state_d  = WAIT;
        bramEn_d = 1'b0;
        bramWe_d = 4'b0000;
        if (mmio_q && (op_q == MEM_WRITE)) begin
          for (int k = 0; k < 4; k++) begin
            if (be_q[k]) outReg_d[8*k +: 8] = wrep_q[8*k +: 8];
          end
        end
      end
      WAIT: begin
        state_d = DONE;
        if (srcData_q) begin
          dataValid_d = 1'b1;
          dataErr_d   = 1'b0;
          if (op_q != MEM_WRITE) loadData_d = w_ext;
        end else begin
          instrValid_d = 1'b1;
          instrErr_d   = 1'b0;
          instrData_d  = bramRdata;
        end
      end
      DONE: begin
        state_d      = IDLE;
        instrValid_d = 1'b0;
        instrErr_d   = 1'b0;
        dataValid_d  = 1'b0;
        dataErr_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      lastInstr_q  <= 1'b1;
      srcData_q    <= 1'b0;
      mmio_q       <= 1'b0;
      op_q         <= MEM_DISABLE;
      size_q       <= SIZE_BYTE;
      lane_q       <= 2'b00;
      be_q         <= 4'b0000;
      wrep_q       <= 32'h0;
      instrValid_q <= 1'b0;
      instrErr_q   <= 1'b0;
      instrData_q  <= 32'h0;
      dataValid_q  <= 1'b0;
      dataErr_q    <= 1'b0;
      loadData_q   <= 32'h0;
      bramEn_q     <= 1'b0;
      bramWe_q     <= 4'b0000;
      bramAddr_q   <= 30'h0;
      bramWdata_q  <= 32'h0;
      outReg_q     <= 32'h0;
    end else begin
      state_q      <= state_d;
      lastInstr_q  <= lastInstr_d;
      srcData_q    <= srcData_d;
      mmio_q       <= mmio_d;
      op_q         <= op_d;
      size_q       <= size_d;
      lane_q       <= lane_d;
      be_q         <= be_d;
      wrep_q       <= wrep_d;
      instrValid_q <= instrValid_d;
      instrErr_q   <= instrErr_d;
      instrData_q  <= instrData_d;
      dataValid_q  <= dataValid_d;
      dataErr_q    <= dataErr_d;
      loadData_q   <= loadData_d;
      bramEn_q     <= bramEn_d;
      bramWe_q     <= bramWe_d;
      bramAddr_q   <= bramAddr_d;
      bramWdata_q  <= bramWdata_d;
      outReg_q     <= outReg_d;
    end
  end

  assign instrValid = instrValid_q;
  assign instrErr   = instrErr_q;
  assign instrData  = instrData_q;
  assign dataValid  = dataValid_q;
  assign dataErr    = dataErr_q;
  assign loadData   = loadData_q;
  assign bramEn     = bramEn_q;
  assign bramWe     = bramWe_q;
  assign bramAddr   = bramAddr_q;
  assign bramWdata  = bramWdata_q;
  assign outReg     = outReg_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// Bench for mem_port_arbiter: directed transactions, BRAM model and a scoreboard
// that checks completions and BRAM port activity against queued expectations.
module tb_mem_port_arbiter;
  localparam logic [1:0] OP_SEXT = 2'b01;
  localparam logic [1:0] OP_ZEXT = 2'b10;
  localparam logic [1:0] OP_WR   = 2'b11;
  localparam logic [1:0] SZ_B    = 2'b00;
  localparam logic [1:0] SZ_H    = 2'b01;
  localparam logic [1:0] SZ_W    = 2'b10;
  localparam logic [31:0] A_IN   = 32'h0200_0000;
  localparam logic [31:0] A_OUT  = 32'h0200_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instrReq = 1'b0;
  logic [31:0] instrAddr = 32'h0;
  logic        instrValid, instrErr;
  logic [31:0] instrData;
  logic        dataReq = 1'b0;
  logic [31:0] dataAddr = 32'h0;
  logic [1:0]  memOp = 2'b00;
  logic [1:0]  memSize = 2'b00;
  logic [31:0] storeData = 32'h0;
  logic        dataValid, dataErr;
  logic [31:0] loadData;
  logic        bramEn;
  logic [3:0]  bramWe;
  logic [29:0] bramAddr;
  logic [31:0] bramWdata;
  logic [31:0] bramRdata = 32'h0;
  logic [31:0] inReg = 32'h0;
  logic [31:0] outReg;

  typedef struct {int cyc; logic err; logic [31:0] data; logic chk;} resp_t;
  typedef struct {int cyc; logic [3:0] we; logic [29:0] addr; logic [31:0] wdata; logic chk_w;} bram_t;

  resp_t data_q[$];
  resp_t instr_q[$];
  bram_t bram_q[$];
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  bit [31:0] mem [0:255];

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .instrReq(instrReq), .instrAddr(instrAddr), .instrValid(instrValid),
    .instrErr(instrErr), .instrData(instrData),
    .dataReq(dataReq), .dataAddr(dataAddr), .memOp(memOp), .memSize(memSize),
    .storeData(storeData), .dataValid(dataValid), .dataErr(dataErr), .loadData(loadData),
    .bramEn(bramEn), .bramWe(bramWe), .bramAddr(bramAddr), .bramWdata(bramWdata),
    .bramRdata(bramRdata), .inReg(inReg), .outReg(outReg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bramEn) begin
      for (int k = 0; k < 4; k++)
        if (bramWe[k]) mem[bramAddr[7:0]][8*k +: 8] <= bramWdata[8*k +: 8];
      bramRdata <= mem[bramAddr[7:0]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    resp_t r;
    bram_t b;
    if (dataValid) begin
      checks++;
      if (data_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected dataValid: got 1 expected 0 at cycle %0d", cyc);
      end else begin
        r = data_q.pop_front();
        check("data cycle", 32'(cyc), 32'(r.cyc));
        check("dataErr", {31'h0, dataErr}, {31'h0, r.err});
        if (r.chk) check("loadData", loadData, r.data);
      end
    end
    if (instrValid) begin
      checks++;
      if (instr_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected instrValid: got 1 expected 0 at cycle %0d", cyc);
      end else begin
        r = instr_q.pop_front();
        check("instr cycle", 32'(cyc), 32'(r.cyc));
        check("instrErr", {31'h0, instrErr}, {31'h0, r.err});
        if (r.chk) check("instrData", instrData, r.data);
      end
    end
    if (bramEn) begin
      checks++;
      if (bram_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected bramEn: got 1 expected 0 at cycle %0d", cyc);
      end else begin
        b = bram_q.pop_front();
        check("bram cycle", 32'(cyc), 32'(b.cyc));
        check("bramWe", {28'h0, bramWe}, {28'h0, b.we});
        check("bramAddr", {2'b00, bramAddr}, {2'b00, b.addr});
        if (b.chk_w) check("bramWdata", bramWdata, b.wdata);
      end
    end
  end

  task automatic wait_valid(input bit is_data, input string name);
    bit got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      got = is_data ? dataValid : instrValid;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s completion: got no valid expected valid within 12 cycles", name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic data_txn(input logic [1:0] op, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] sd,
                          input int lat, input logic err,
                          input logic [31:0] exp_d, input logic chk_d,
                          input logic bram, input logic [3:0] we, input logic [31:0] wd);
    dataReq   = 1'b1;
    memOp     = op;
    memSize   = sz;
    dataAddr  = a;
    storeData = sd;
    data_q.push_back('{cyc + lat, err, exp_d, chk_d});
    if (bram) bram_q.push_back('{cyc + lat - 2, we, a[31:2], wd, (op == OP_WR)});
    wait_valid(1'b1, "data");
    dataReq = 1'b0;
    memOp   = 2'b00;
  endtask

  task automatic instr_txn(input logic [31:0] a, input int lat, input logic err,
                           input logic [31:0] exp_d, input logic bram);
    instrReq  = 1'b1;
    instrAddr = a;
    instr_q.push_back('{cyc + lat, err, exp_d, 1'b1});
    if (bram) bram_q.push_back('{cyc + lat - 2, 4'h0, a[31:2], 32'h0, 1'b0});
    wait_valid(1'b0, "instr");
    instrReq = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    repeat (3) @(posedge clk);
    #1;
    check("rst bramEn", {31'h0, bramEn}, 32'h0);
    check("rst bramWe", {28'h0, bramWe}, 32'h0);
    check("rst bramAddr", {2'b00, bramAddr}, 32'h0);
    check("rst bramWdata", bramWdata, 32'h0);
    check("rst instrValid", {31'h0, instrValid}, 32'h0);
    check("rst instrErr", {31'h0, instrErr}, 32'h0);
    check("rst instrData", instrData, 32'h0);
    check("rst dataValid", {31'h0, dataValid}, 32'h0);
    check("rst dataErr", {31'h0, dataErr}, 32'h0);
    check("rst loadData", loadData, 32'h0);
    check("rst outReg", outReg, 32'h0);

    // Both requesters up at reset release: data wins, fetch follows and sees the store.
    bram_q.push_back('{cyc + 1, 4'hF, 30'h4, 32'hDEADBEEF, 1'b1});
    bram_q.push_back('{cyc + 5, 4'h0, 30'h4, 32'h0, 1'b0});
    reset = 1'b1;
    fork
      data_txn(OP_WR, SZ_W, 32'h10, 32'hDEADBEEF, 3, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0);
      instr_txn(32'h10, 7, 1'b0, 32'hDEADBEEF, 1'b0);
    join

    data_txn(OP_WR, SZ_W, 32'h20, 32'h80FF7F01, 3, 1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h80FF7F01);
    data_txn(OP_SEXT, SZ_B, 32'h22, 32'h0, 3, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 4'h0, 32'h0);
    data_txn(OP_ZEXT, SZ_B, 32'h23, 32'h0, 3, 1'b0, 32'h00000080, 1'b1, 1'b1, 4'h0, 32'h0);
    data_txn(OP_SEXT, SZ_H, 32'h22, 32'h0, 3, 1'b0, 32'hFFFF80FF, 1'b1, 1'b1, 4'h0, 32'h0);
    data_txn(OP_ZEXT, SZ_H, 32'h20, 32'h0, 3, 1'b0, 32'h00007F01, 1'b1, 1'b1, 4'h0, 32'h0);

    data_txn(OP_WR, SZ_B, 32'h31, 32'h123456AB, 3, 1'b0, 32'h00007F01, 1'b1, 1'b1, 4'b0010, 32'hABABABAB);
    data_txn(OP_WR, SZ_H, 32'h33, 32'h1234, 1, 1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
    data_txn(OP_ZEXT, SZ_W, 32'h22, 32'h0, 1, 1'b1, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0);
    data_txn(OP_ZEXT, SZ_W, 32'h30, 32'h0, 3, 1'b0, 32'h0000AB00, 1'b1, 1'b1, 4'h0, 32'h0);

    data_txn(OP_WR, SZ_W, A_OUT, 32'h12345678, 3, 1'b0, 32'h0000AB00, 1'b1, 1'b0, 4'h0, 32'h0);
    check("outReg word", outReg, 32'h12345678);
    data_txn(OP_WR, SZ_B, A_OUT, 32'h0000005A, 3, 1'b0, 32'h0000AB00, 1'b1, 1'b0, 4'h0, 32'h0);
    check("outReg byte", outReg, 32'h1234565A);
    data_txn(OP_ZEXT, SZ_W, A_OUT, 32'h0, 1, 1'b1, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0);
    inReg = 32'hCAFEBABE;
    data_txn(OP_ZEXT, SZ_W, A_IN, 32'h0, 3, 1'b0, 32'hCAFEBABE, 1'b1, 1'b0, 4'h0, 32'h0);
    data_txn(OP_SEXT, SZ_H, A_IN, 32'h0, 3, 1'b0, 32'hFFFFBABE, 1'b1, 1'b0, 4'h0, 32'h0);
    data_txn(OP_ZEXT, SZ_W, 32'h007FFF00, 32'h0, 3, 1'b0, 32'h0, 1'b1, 1'b1, 4'h0, 32'h0);
    data_txn(OP_WR, SZ_W, A_IN, 32'h1, 1, 1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0);
    data_txn(OP_ZEXT, SZ_W, 32'h007FFF04, 32'h0, 1, 1'b1, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0);

    instr_txn(A_IN, 1, 1'b1, 32'h0, 1'b0);
    instr_txn(32'h22, 1, 1'b1, 32'h0, 1'b0);
    instr_txn(32'h00800000, 1, 1'b1, 32'h0, 1'b0);

    // Both held: last grant was a fetch, so data goes first, then strict alternation.
    c = cyc;
    dataReq = 1'b1; memOp = OP_ZEXT; memSize = SZ_W; dataAddr = 32'h20;
    instrReq = 1'b1; instrAddr = 32'h10;
    for (int i = 0; i < 2; i++) begin
      data_q.push_back('{c + 3 + 8*i, 1'b0, 32'h80FF7F01, 1'b1});
      instr_q.push_back('{c + 7 + 8*i, 1'b0, 32'hDEADBEEF, 1'b1});
      bram_q.push_back('{c + 1 + 8*i, 4'h0, 30'h8, 32'h0, 1'b0});
      bram_q.push_back('{c + 5 + 8*i, 4'h0, 30'h4, 32'h0, 1'b0});
    end
    repeat (16) @(posedge clk);
    #1;
    dataReq = 1'b0; instrReq = 1'b0;
    @(posedge clk);
    #1;

    // Reset while the load sits in WAIT: everything clears, then the held request reruns.
    dataReq = 1'b1; memOp = OP_ZEXT; memSize = SZ_H; dataAddr = 32'h22;
    bram_q.push_back('{cyc + 1, 4'h0, 30'h8, 32'h0, 1'b0});
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort dataValid", {31'h0, dataValid}, 32'h0);
    check("abort bramEn", {31'h0, bramEn}, 32'h0);
    check("abort loadData", loadData, 32'h0);
    check("abort outReg", outReg, 32'h0);
    check("abort instrData", instrData, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    data_txn(OP_ZEXT, SZ_H, 32'h22, 32'h0, 3, 1'b0, 32'h000080FF, 1'b1, 1'b1, 4'h0, 32'h0);

    repeat (4) @(posedge clk);
    #1;
    check("data queue drained", 32'(data_q.size()), 32'h0);
    check("instr queue drained", 32'(instr_q.size()), 32'h0);
    check("bram queue drained", 32'(bram_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
